// File: rtl/dct_pkg.sv
// Shared definitions for the avalon_dct slave and its host-side initiator:
// data width, slave register addresses and the host sequencer states.
package dct_pkg;

    localparam int NBITS = 16;

    localparam logic [7:0] DCT_ADDR_LEN  = 8'd0;
    localparam logic [7:0] DCT_ADDR_DATA = 8'd1;
    localparam logic [7:0] DCT_ADDR_M    = 8'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_M,
        ST_WR_LEN,
        ST_WR_DATA,
        ST_RD_REQ,
        ST_RD_GAP,
        ST_FIN
    } host_state_t;

endpackage

// File: rtl/dct_avalon_host.sv
// Avalon-MM initiator for the avalon_dct slave: programs M and length,
// streams samples into the data FIFO, then reads every coefficient back
// (each gated by slv_done, bounded by TIMEOUT) and emits them indexed.
module dct_avalon_host #(
    parameter int NBITS   = 16,
    parameter int MAX_LEN = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         start,
    input  logic [NBITS-1:0]             cfg_m,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic [NBITS-1:0]             sample_data,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    output logic [7:0]                   addr,
    output logic                         read,
    output logic                         write,
    output logic [NBITS-1:0]             writedata,
    input  logic [NBITS-1:0]             readdata,
    input  logic                         slv_done,
    output logic [NBITS-1:0]             coef_data,
    output logic [7:0]                   coef_idx,
    output logic                         coef_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);
    import dct_pkg::*;

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] MAX_LEN_L  = LW'(MAX_LEN);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

    host_state_t state, state_nx;

    logic [NBITS-1:0] m_q;
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    wr_cnt;
    logic [7:0]       rd_idx;
    logic [WW-1:0]    wait_cnt;
    logic             err_q;
    logic             rej_q;

    logic [NBITS-1:0] coef_data_p1;
    logic [7:0]       coef_idx_p1;
    logic             vld_p1;

    logic             last_sample;
    logic             last_coef;

    assign last_sample = (wr_cnt == LW'(len_q - LW'(1)));
    assign last_coef   = (8'(rd_idx + 8'd1) == 8'(len_q));

    // Configuration is captured only when a legal start is accepted
    always_ff @(posedge Clock) begin
        if (state == ST_IDLE && start && cfg_len <= MAX_LEN_L) begin
            m_q   <= cfg_m;
            len_q <= cfg_len;
        end
    end

    // State register, counters, error flags and the coefficient capture stage
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= ST_IDLE;
            wr_cnt       <= '0;
            rd_idx       <= '0;
            wait_cnt     <= '0;
            err_q        <= 1'b0;
            rej_q        <= 1'b0;
            coef_data_p1 <= '0;
            coef_idx_p1  <= '0;
            vld_p1       <= 1'b0;
        end else begin
            state  <= state_nx;
            rej_q  <= 1'b0;
            vld_p1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    err_q  <= 1'b0;
                    wr_cnt <= '0;
                    if (start && cfg_len > MAX_LEN_L)
                        rej_q <= 1'b1;
                end
                ST_WR_DATA: begin
                    rd_idx   <= '0;
                    wait_cnt <= '0;
                    if (sample_valid)
                        wr_cnt <= wr_cnt + LW'(1);
                end
                ST_RD_REQ: begin
                    wait_cnt <= wait_cnt + WW'(1);
                    if (slv_done) begin
                        coef_data_p1 <= readdata;
                        coef_idx_p1  <= rd_idx;
                        vld_p1       <= 1'b1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err_q <= 1'b1;
                    end
                end
                ST_RD_GAP: begin
                    rd_idx   <= rd_idx + 8'd1;
                    wait_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic and Avalon strobes decoded from the current state
    always_comb begin
        state_nx     = state;
        read         = 1'b0;
        write        = 1'b0;
        addr         = 8'd0;
        writedata    = '0;
        sample_ready = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && cfg_len <= MAX_LEN_L)
                    state_nx = ST_WR_M;
            end
            ST_WR_M: begin
                write     = 1'b1;
                addr      = DCT_ADDR_M;
                writedata = m_q;
                state_nx  = ST_WR_LEN;
            end
            ST_WR_LEN: begin
                write     = 1'b1;
                addr      = DCT_ADDR_LEN;
                writedata = NBITS'(len_q);
                state_nx  = (len_q == '0) ? ST_FIN : ST_WR_DATA;
            end
            ST_WR_DATA: begin
                sample_ready = 1'b1;
                addr         = DCT_ADDR_DATA;
                write        = sample_valid;
                writedata    = sample_data;
                if (sample_valid && last_sample)
                    state_nx = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                read = 1'b1;
                addr = rd_idx;
                if (slv_done)
                    state_nx = ST_RD_GAP;
                else if (wait_cnt == WAIT_LAST)
                    state_nx = ST_FIN;
            end
            ST_RD_GAP: begin
                state_nx = last_coef ? ST_FIN : ST_RD_REQ;
            end
            ST_FIN: begin
                done     = 1'b1;
                error    = err_q;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // A rejected length completes from IDLE without any bus traffic
        if (rej_q) begin
            done  = 1'b1;
            error = 1'b1;
        end
    end

    assign busy       = (state != ST_IDLE);
    assign coef_data  = coef_data_p1;
    assign coef_idx   = coef_idx_p1;
    assign coef_valid = vld_p1;

endmodule

// File: tb/tb_dct_avalon_host.sv
// Scoreboard bench for dct_avalon_host with a small avalon_dct slave model
// (slv_done on the 4th consecutive read cycle, readdata = addr * 256).
module tb_dct_avalon_host;
    import dct_pkg::*;

    localparam int NB   = 16;
    localparam int MAXL = 32;
    localparam int TO   = 64;
    localparam int LW   = $clog2(MAXL + 1);

    logic          Clock = 1'b0;
    logic          Reset;
    logic          start;
    logic [NB-1:0] cfg_m;
    logic [LW-1:0] cfg_len;
    logic [NB-1:0] sample_data;
    logic          sample_valid;
    logic          sample_ready;
    logic [7:0]    addr;
    logic          read;
    logic          write;
    logic [NB-1:0] writedata;
    logic [NB-1:0] readdata;
    logic          slv_done;
    logic [NB-1:0] coef_data;
    logic [7:0]    coef_idx;
    logic          coef_valid;
    logic          busy;
    logic          done;
    logic          error;

    dct_avalon_host #(.NBITS(NB), .MAX_LEN(MAXL), .TIMEOUT(TO)) dut (
        .Clock(Clock), .Reset(Reset), .start(start), .cfg_m(cfg_m), .cfg_len(cfg_len),
        .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .addr(addr), .read(read), .write(write), .writedata(writedata),
        .readdata(readdata), .slv_done(slv_done), .coef_data(coef_data),
        .coef_idx(coef_idx), .coef_valid(coef_valid), .busy(busy), .done(done), .error(error)
    );

    always #5 Clock = ~Clock;

    // Slave model
    int         rd_cnt = 0;
    logic       stall_en = 1'b0;
    logic [7:0] stall_addr = 8'd0;
    always @(posedge Clock) rd_cnt <= read ? rd_cnt + 1 : 0;
    assign slv_done = read && (rd_cnt == 3) && !(stall_en && addr == stall_addr);
    assign readdata = {addr, 8'h00};

    typedef struct packed { logic [7:0] a; logic [15:0] d; } ad_t;
    typedef struct { logic [7:0] a; int n; } rd_t;

    ad_t  wr_q[$];
    ad_t  coef_q[$];
    rd_t  rd_q[$];
    logic done_q[$];

    int tests = 0, fails = 0;
    int extra_wr = 0, extra_rd = 0, extra_coef = 0, extra_done = 0;

    function automatic void chk(string name, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents bus or stream activity
    logic       in_run = 1'b0;
    int         run_len = 0, run_exp = 0;
    logic [7:0] run_addr = 8'd0;
    always @(negedge Clock) begin
        ad_t  e;
        rd_t  r;
        logic de;
        if (Reset) begin
            wr_q.delete(); coef_q.delete(); rd_q.delete(); done_q.delete();
            in_run = 1'b0;
        end else begin
            if (read && write) chk("read_write_overlap", 1, 0);
            if (write) begin
                if (wr_q.size() == 0) extra_wr++;
                else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", addr, e.a);
                    chk("wr_data", writedata, e.d);
                end
            end
            if (read) begin
                if (!in_run) begin
                    in_run = 1'b1; run_len = 1; run_addr = addr;
                    if (rd_q.size() == 0) begin extra_rd++; run_exp = -1; end
                    else begin
                        r = rd_q.pop_front();
                        chk("rd_addr", addr, r.a);
                        run_exp = r.n;
                    end
                end else begin
                    run_len++;
                    if (addr != run_addr) chk("rd_addr_steady", addr, run_addr);
                end
            end else if (in_run) begin
                in_run = 1'b0;
                if (run_exp >= 0) chk("rd_hold_len", run_len, run_exp);
            end
            if (coef_valid) begin
                if (coef_q.size() == 0) extra_coef++;
                else begin
                    e = coef_q.pop_front();
                    chk("coef_idx", coef_idx, e.a);
                    chk("coef_data", coef_data, e.d);
                end
            end
            if (done) begin
                if (done_q.size() == 0) extra_done++;
                else begin
                    de = done_q.pop_front();
                    chk("done_error", error, de);
                end
            end
        end
    end

    function automatic logic [15:0] sdata(int base, int step, int i);
        return 16'(base + i * step);
    endfunction

    task automatic push_exp(input logic [15:0] m, input int len, input int base,
                            input int step, input int stall_at);
        int nrd, ncf;
        if (len > MAXL) begin
            done_q.push_back(1'b1);
            return;
        end
        wr_q.push_back({DCT_ADDR_M, m});
        wr_q.push_back({DCT_ADDR_LEN, 16'(len)});
        for (int i = 0; i < len; i++) wr_q.push_back({DCT_ADDR_DATA, sdata(base, step, i)});
        nrd = (stall_at >= 0 && stall_at < len) ? stall_at + 1 : len;
        ncf = (stall_at >= 0 && stall_at < len) ? stall_at : len;
        for (int k = 0; k < nrd; k++) begin
            rd_t r;
            r.a = 8'(k);
            r.n = (k == stall_at) ? TO : 4;
            rd_q.push_back(r);
        end
        for (int k = 0; k < ncf; k++) coef_q.push_back({8'(k), 16'(k * 256)});
        done_q.push_back((stall_at >= 0 && stall_at < len) ? 1'b1 : 1'b0);
    endtask

    task automatic do_run(input string tag, input logic [15:0] m, input int len,
                          input int base, input int step, input int stall_at,
                          input int stall_after, input bit start_busy, input int exp_cyc);
        int   i = 0, cyc = 0, stall_left = 0;
        bit   stalled = 0, pulsed = 0, seen = 0;
        logic rdy = 1'b0, busy_at_done = 1'b0;
        stall_en   = (stall_at >= 0);
        stall_addr = 8'(stall_at);
        push_exp(m, len, base, step, stall_at);
        extra_wr = 0; extra_rd = 0; extra_coef = 0; extra_done = 0;
        @(posedge Clock); #1;
        cfg_m = m; cfg_len = LW'(len); start = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0; cyc = 1;
        while (cyc < 400) begin
            if (start_busy && i == 3 && !pulsed) begin
                start = 1'b1; cfg_len = LW'(5); cfg_m = 16'd1; pulsed = 1;
            end else start = 1'b0;
            if (stall_after >= 0 && i == stall_after && !stalled) begin
                stalled = 1; stall_left = 2;
            end
            if (stall_left > 0) begin
                sample_valid = 1'b0; stall_left--;
            end else begin
                sample_valid = (i < len);
            end
            sample_data = sdata(base, step, i);
            @(negedge Clock);
            rdy = sample_ready;
            if (done) begin seen = 1; busy_at_done = busy; break; end
            @(posedge Clock); #1;
            if (rdy && sample_valid) i++;
            cyc++;
        end
        start = 1'b0; sample_valid = 1'b0;
        if (!seen) $display("FAIL %s_done_wait: done not seen within bound", tag);
        chk({tag, "_done_cycle"}, cyc, exp_cyc);
        chk({tag, "_busy_at_done"}, busy_at_done, (len > MAXL) ? 0 : 1);
        repeat (4) @(posedge Clock);
        #1;
        chk({tag, "_writes_left"}, wr_q.size(), 0);
        chk({tag, "_reads_left"}, rd_q.size(), 0);
        chk({tag, "_coefs_left"}, coef_q.size(), 0);
        chk({tag, "_dones_left"}, done_q.size(), 0);
        chk({tag, "_extra_events"}, extra_wr + extra_rd + extra_coef + extra_done, 0);
        stall_en = 1'b0;
    endtask

    initial begin
        int n;
        Reset = 1'b1; start = 1'b0; cfg_m = '0; cfg_len = '0;
        sample_data = '0; sample_valid = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_addr", addr, 0);
        chk("rst_read", read, 0);
        chk("rst_write", write, 0);
        chk("rst_writedata", writedata, 0);
        chk("rst_sample_ready", sample_ready, 0);
        chk("rst_coef_valid", coef_valid, 0);
        chk("rst_coef_data", coef_data, 0);
        chk("rst_coef_idx", coef_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        Reset = 1'b0;

        // 3 + len data cycles + 5 per coefficient, then FIN
        do_run("nominal", 16'd6, 10, 'h1800, 0, -1, -1, 0, 63);
        do_run("stall", 16'd6, 10, 'h1000, 1, -1, 4, 0, 65);
        do_run("timeout", 16'd6, 10, 'h1800, 0, 4, -1, 0, 97);
        do_run("len0", 16'd6, 0, 0, 0, -1, -1, 0, 3);
        do_run("len33", 16'd6, 33, 0, 0, -1, -1, 0, 1);
        do_run("start_busy", 16'd6, 10, 'h1800, 0, -1, -1, 1, 63);

        // Reset while the read of coefficient 2 is outstanding
        push_exp(16'd6, 10, 'h1800, 0, -1);
        extra_done = 0;
        @(posedge Clock); #1;
        cfg_m = 16'd6; cfg_len = LW'(10); start = 1'b1; sample_data = 16'h1800; sample_valid = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
        n = 0;
        while (n < 200) begin
            @(negedge Clock);
            if (read && addr == 8'd2) break;
            n++;
        end
        chk("rst_mid_reached_idx2", n < 200, 1);
        @(posedge Clock); #1;
        Reset = 1'b1; sample_valid = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b0;
        chk("rst_mid_read", read, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        repeat (5) @(posedge Clock);
        #1;
        chk("rst_mid_no_done", extra_done, 0);
        do_run("after_reset", 16'd6, 10, 'h1800, 0, -1, -1, 0, 63);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
